// File: rtl/acorn_stream_sequencer_if.sv
// Handshake and control bundle between acorn_stream_sequencer (slave side)
// and its word source / cipher-core sink (master side).
interface acorn_stream_sequencer_if #(
  parameter int WORD_W = 32,
  parameter int LEN_W  = 16
);
  logic              start;
  logic [LEN_W-1:0]  ad_len;
  logic [LEN_W-1:0]  msg_len;
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic              mbit_out;
  logic              ca_out;
  logic              cb_out;
  logic [1:0]        phase;
  logic              busy;
  logic              done;

  modport master (
    output start, ad_len, msg_len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, mbit_out, ca_out, cb_out, phase, busy, done
  );

  modport slave (
    input  start, ad_len, msg_len, in_valid, in_data, out_ready,
    output in_ready, out_valid, mbit_out, ca_out, cb_out, phase, busy, done
  );
endinterface

// File: rtl/acorn_stream_sequencer.sv
// ACORN bit-stream sequencer: serialises AD and message words into mbit/ca/cb with 256-bit pads.
// Optional sticky protocol-error output enabled by defining ACORN_SEQ_ERR_EN.
module acorn_stream_sequencer #(
  parameter int WORD_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  acorn_stream_sequencer_if.slave  sif
`ifdef ACORN_SEQ_ERR_EN
  ,
  output logic                     err
`endif
);

  localparam int IDX_W = $clog2(WORD_W);
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_AD      = 3'd1,
    S_AD_PAD  = 3'd2,
    S_MSG     = 3'd3,
    S_MSG_PAD = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  ad_len_q, ad_len_d;
  logic [LEN_W-1:0]  msg_len_q, msg_len_d;
  logic [LEN_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]        pad_cnt_q, pad_cnt_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [WORD_W-1:0] buf0_q, buf0_d;
  logic [WORD_W-1:0] buf1_q, buf1_d;
  logic [1:0]        fill_q, fill_d;

  logic              data_st_s;
  logic              in_ready_s;
  logic              out_valid_s;
  logic              pop_s;
  logic              push_s;
  logic              last_bit_s;
  logic              mbit_s, ca_s, cb_s;
  logic              start_s;
  logic [LEN_W-1:0]  cur_len_s;
  logic [1:0]        fill_pop_s;
  logic [1:0]        phase_s;

  // FSM next state, counters and bit outputs
  always_comb begin
    state_d     = state_q;
    ad_len_d    = ad_len_q;
    msg_len_d   = msg_len_q;
    bit_cnt_d   = bit_cnt_q;
    pad_cnt_d   = pad_cnt_q;
    bit_idx_d   = bit_idx_q;
    out_valid_s = 1'b0;
    mbit_s      = 1'b0;
    ca_s        = 1'b0;
    cb_s        = 1'b0;
    pop_s       = 1'b0;
    phase_s     = 2'd0;
    start_s     = 1'b0;
    data_st_s   = (state_q == S_AD) || (state_q == S_MSG);
    cur_len_s   = (state_q == S_AD) ? ad_len_q : msg_len_q;
    last_bit_s  = (bit_cnt_q == (cur_len_s - LEN_ONE));
    in_ready_s  = data_st_s && (fill_q != 2'd2);

    case (state_q)
      S_IDLE: begin
        if (sif.start) begin
          start_s   = 1'b1;
          ad_len_d  = sif.ad_len;
          msg_len_d = sif.msg_len;
          bit_cnt_d = LEN_ZERO;
          pad_cnt_d = 8'd0;
          bit_idx_d = {IDX_W{1'b0}};
          state_d   = (sif.ad_len == LEN_ZERO) ? S_AD_PAD : S_AD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_AD, S_MSG: begin
        phase_s     = (state_q == S_AD) ? 2'd1 : 2'd2;
        out_valid_s = (fill_q != 2'd0);
        if (out_valid_s) begin
          mbit_s = buf0_q[bit_idx_q];
          ca_s   = 1'b1;
          cb_s   = (state_q == S_AD);
        end else begin
          mbit_s = 1'b0;
        end
        // A phase's final bit also drops the rest of its word
        if (out_valid_s && sif.out_ready) begin
          pop_s     = last_bit_s || (bit_idx_q == IDX_LAST);
          bit_idx_d = pop_s ? {IDX_W{1'b0}} : (bit_idx_q + IDX_ONE);
          if (last_bit_s) begin
            bit_cnt_d = LEN_ZERO;
            state_d   = (state_q == S_AD) ? S_AD_PAD : S_MSG_PAD;
          end else begin
            bit_cnt_d = bit_cnt_q + LEN_ONE;
          end
        end else begin
          pop_s = 1'b0;
        end
      end
      S_AD_PAD, S_MSG_PAD: begin
        phase_s     = (state_q == S_AD_PAD) ? 2'd1 : 2'd2;
        out_valid_s = 1'b1;
        mbit_s      = (pad_cnt_q == 8'd0);
        ca_s        = ~pad_cnt_q[7];
        cb_s        = (state_q == S_AD_PAD);
        if (sif.out_ready) begin
          pad_cnt_d = pad_cnt_q + 8'd1;
          if (pad_cnt_q == 8'd255) begin
            if (state_q == S_MSG_PAD) begin
              state_d = S_DONE;
            end else begin
              state_d = (msg_len_q == LEN_ZERO) ? S_MSG_PAD : S_MSG;
            end
          end else begin
            state_d = state_q;
          end
        end else begin
          pad_cnt_d = pad_cnt_q;
        end
      end
      S_DONE: begin
        phase_s = 2'd3;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Two-entry word buffer: pop shifts next into current, push fills first free slot
  always_comb begin
    push_s     = sif.in_valid && in_ready_s;
    fill_pop_s = fill_q - {1'b0, pop_s};
    buf0_d     = pop_s ? buf1_q : buf0_q;
    buf1_d     = buf1_q;
    if (push_s) begin
      if (fill_pop_s == 2'd0) begin
        buf0_d = sif.in_data;
      end else begin
        buf1_d = sif.in_data;
      end
    end else begin
      buf1_d = buf1_q;
    end
    if (start_s) begin
      fill_d = 2'd0;
    end else begin
      fill_d = fill_pop_s + {1'b0, push_s};
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ad_len_q  <= LEN_ZERO;
      msg_len_q <= LEN_ZERO;
      bit_cnt_q <= LEN_ZERO;
      pad_cnt_q <= 8'd0;
      bit_idx_q <= {IDX_W{1'b0}};
      buf0_q    <= {WORD_W{1'b0}};
      buf1_q    <= {WORD_W{1'b0}};
      fill_q    <= 2'd0;
    end else begin
      ad_len_q  <= ad_len_d;
      msg_len_q <= msg_len_d;
      bit_cnt_q <= bit_cnt_d;
      pad_cnt_q <= pad_cnt_d;
      bit_idx_q <= bit_idx_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      fill_q    <= fill_d;
    end
  end

  assign sif.in_ready  = in_ready_s;
  assign sif.out_valid = out_valid_s;
  assign sif.mbit_out  = mbit_s;
  assign sif.ca_out    = ca_s;
  assign sif.cb_out    = cb_s;
  assign sif.phase     = phase_s;
  assign sif.busy      = (state_q != S_IDLE);
  assign sif.done      = (state_q == S_DONE);

`ifdef ACORN_SEQ_ERR_EN
  logic err_q;

  // Sticky protocol error: start while busy, or a word offered when it cannot be taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((sif.start && (state_q != S_IDLE)) ||
                 (sif.in_valid && !in_ready_s && data_st_s)) begin
      err_q <= 1'b1;
    end else begin
      err_q <= err_q;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_acorn_stream_sequencer.sv
// Scoreboard bench for acorn_stream_sequencer: expected bits are queued from the
// lengths and words when a sequence starts, and popped on each transfer.
module tb_acorn_stream_sequencer;
  localparam int W  = 32;
  localparam int LW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  acorn_stream_sequencer_if #(.WORD_W(W), .LEN_W(LW)) bus ();
`ifdef ACORN_SEQ_ERR_EN
  logic err;
`endif

  acorn_stream_sequencer #(.WORD_W(W), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .sif (bus.slave)
`ifdef ACORN_SEQ_ERR_EN
    ,
    .err (err)
`endif
  );

  int total = 0;
  int bad   = 0;
  logic [4:0] sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] all_out();
    return {23'd0, bus.in_ready, bus.out_valid, bus.busy, bus.done, bus.phase,
            bus.mbit_out, bus.ca_out, bus.cb_out};
  endfunction

  task automatic run_seq(input int ad, input int ml, input int gap_word, input int bp_at,
                         input int bs_at, input int abort_at, input bit no_bubble);
    logic [31:0] words[$];
    logic [31:0] w;
    int nad, nmsg, nw, xfer, cycles, bubbles, bp_cnt, gap_cnt, exp_total;
    bit finished, bs_done, allowed, bp_on, aborted;
    nw = 0; xfer = 0; cycles = 0; bubbles = 0; bp_cnt = 0; gap_cnt = 0;
    finished = 1'b0; bs_done = 1'b0; aborted = 1'b0;
    nad  = (ad + W - 1) / W;
    nmsg = (ml + W - 1) / W;
    for (int k = 0; k < nad + nmsg; k++) words.push_back($urandom);
    sb.delete();
    for (int i = 0; i < ad; i++) begin
      w = words[i / W];
      sb.push_back({2'd1, w[i % W], 1'b1, 1'b1});
    end
    for (int p = 0; p < 256; p++) sb.push_back({2'd1, (p == 0), (p < 128), 1'b1});
    for (int j = 0; j < ml; j++) begin
      w = words[nad + j / W];
      sb.push_back({2'd2, w[j % W], 1'b1, 1'b0});
    end
    for (int p = 0; p < 256; p++) sb.push_back({2'd2, (p == 0), (p < 128), 1'b0});
    exp_total = sb.size();

    @(negedge clk);
    bus.start   = 1'b1;
    bus.ad_len  = ad[LW-1:0];
    bus.msg_len = ml[LW-1:0];
    @(negedge clk);
    bus.start = 1'b0;

    while (!finished && !aborted && cycles < 3000) begin
      bp_on = (bp_at >= 0) && (xfer >= bp_at) && (bp_cnt < 3);
      bus.out_ready = !bp_on;
      allowed = !((nw == gap_word) && ((xfer < gap_word * W) || (gap_cnt < 5)));
      if ((nw == gap_word) && (xfer >= gap_word * W) && (gap_cnt < 5)) gap_cnt++;
      bus.in_valid = (nw < words.size()) && allowed && bus.in_ready;
      bus.in_data  = (nw < words.size()) ? words[nw] : $urandom;
      bus.start    = (bs_at >= 0) && (xfer == bs_at) && !bs_done;
      if (bus.start) begin
        bs_done     = 1'b1;
        bus.ad_len  = 16'($urandom);
        bus.msg_len = 16'($urandom);
      end
      #1;
      if (abort_at >= 0 && xfer == abort_at) begin
        aborted = 1'b1;
      end else begin
        if (bus.out_valid) begin
          if (sb.size() == 0) begin
            check_eq("extra_bit", 32'(xfer), 32'(exp_total));
            finished = 1'b1;
          end else begin
            check_eq("bit", 32'({bus.phase, bus.mbit_out, bus.ca_out, bus.cb_out}), 32'(sb[0]));
            if (bus.out_ready) begin
              void'(sb.pop_front());
              xfer++;
            end
          end
        end else begin
          check_eq("gate0", 32'({bus.mbit_out, bus.ca_out, bus.cb_out}), 32'd0);
          if (xfer > 0 && bus.busy && !bus.done) bubbles++;
        end
        if (bp_on) begin
          check_eq("bp_valid", 32'(bus.out_valid), 32'd1);
          bp_cnt++;
        end
        if (bus.in_valid && bus.in_ready) nw++;
        if (bus.done) begin
          check_eq("done_phase", 32'(bus.phase), 32'd3);
          check_eq("done_last", 32'(sb.size()), 32'd0);
          finished = 1'b1;
        end
        cycles++;
        @(negedge clk);
      end
    end

    bus.in_valid  = 1'b0;
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    if (aborted) begin
      rst = 1'b1;
      #1 check_eq("rst_outs", all_out(), 32'd0);
      @(negedge clk);
      #1 check_eq("rst_hold", all_out(), 32'd0);
      rst = 1'b0;
      repeat (4) begin
        @(negedge clk);
        #1 check_eq("post_rst", all_out(), 32'd0);
      end
    end else begin
      check_eq("finished", 32'(finished), 32'd1);
      check_eq("xfers", 32'(xfer), 32'(exp_total));
      if (no_bubble) check_eq("bubbles", 32'(bubbles), 32'd0);
      if (gap_word >= 0) check_eq("starve", 32'(bubbles >= 5), 32'd1);
      @(negedge clk);
      #1 check_eq("back_idle", 32'({bus.busy, bus.done, bus.phase}), 32'd0);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.ad_len    = 16'd0;
    bus.msg_len   = 16'd0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'd0;
    bus.out_ready = 1'b1;
    #1 check_eq("reset_outs", all_out(), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1 check_eq("idle_outs", all_out(), 32'd0);
`ifdef ACORN_SEQ_ERR_EN
    check_eq("err_reset", 32'(err), 32'd0);
`endif
    run_seq(128, 0,  -1, -1, -1, -1, 1'b1);
    run_seq(0,   40, -1, -1, -1, -1, 1'b0);
    run_seq(33,  1,  -1, -1, -1, -1, 1'b0);
    run_seq(128, 0,   2, -1, -1, -1, 1'b0);
    run_seq(64,  8,  -1, 20, -1, -1, 1'b0);
    run_seq(128, 0,  -1, -1, -1, 50, 1'b0);
    run_seq(96,  16, -1, -1, -1, -1, 1'b0);
`ifdef ACORN_SEQ_ERR_EN
    check_eq("err_clean", 32'(err), 32'd0);
`endif
    run_seq(32,  32, -1, -1, 10, -1, 1'b0);
`ifdef ACORN_SEQ_ERR_EN
    check_eq("err_set", 32'(err), 32'd1);
    repeat (3) @(negedge clk);
    #1 check_eq("err_sticky", 32'(err), 32'd1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
